// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blanking and boundary decodes.
// Optional frame counter built when VGA_TIMING_FRAME_CNT_EN is defined; otherwise frame_cnt reads 0.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_end,
  output logic [9:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  // Phase bounds are 11 bits so a sync phase ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_LO = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_HI = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_LO = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_HI = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_reg, v_reg, h_next, v_next;
  logic       visible_reg, hsync_reg, vsync_reg, line_end_reg, frame_end_reg;
  logic       visible_next, hsync_next, vsync_next, line_end_next, frame_end_next;

  // Decodes are taken from the next position so they land in the same cycle as hpos/vpos.
  always_comb begin
    h_next = h_reg + 10'd1;
    v_next = v_reg;
    if (h_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
    end
    visible_next   = ({1'b0, h_next} < H_VIS) && ({1'b0, v_next} < V_VIS);
    hsync_next     = (({1'b0, h_next} >= H_SYNC_LO) && ({1'b0, h_next} < H_SYNC_HI)) ?
                     SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_next     = (({1'b0, v_next} >= V_SYNC_LO) && ({1'b0, v_next} < V_SYNC_HI)) ?
                     SYNC_ACTIVE : ~SYNC_ACTIVE;
    line_end_next  = (h_next == H_LAST);
    frame_end_next = line_end_next && (v_next == V_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg         <= '0;
      v_reg         <= '0;
      visible_reg   <= 1'b1;
      hsync_reg     <= ~SYNC_ACTIVE;
      vsync_reg     <= ~SYNC_ACTIVE;
      line_end_reg  <= 1'b0;
      frame_end_reg <= 1'b0;
    end else begin
      h_reg         <= h_next;
      v_reg         <= v_next;
      visible_reg   <= visible_next;
      hsync_reg     <= hsync_next;
      vsync_reg     <= vsync_next;
      line_end_reg  <= line_end_next;
      frame_end_reg <= frame_end_next;
    end
  end

  assign hpos      = h_reg;
  assign vpos      = v_reg;
  assign visible   = visible_reg;
  assign hsync     = hsync_reg;
  assign vsync     = vsync_reg;
  assign line_end  = line_end_reg;
  assign frame_end = frame_end_reg;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [9:0] frame_cnt_reg;
  logic       frame_wrap;

  assign frame_wrap = (h_reg == H_LAST) && (v_reg == V_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt_reg <= '0;
    else if (frame_wrap)
      frame_cnt_reg <= frame_cnt_reg + 10'd1;
  end

  assign frame_cnt = frame_cnt_reg;
`else
  assign frame_cnt = '0;
`endif

endmodule
